// File: rtl/match_group_fsm.sv
// Game-flow controller for the memory game: menus, shuffle handshake and turn handling
// for groups of GROUP equal cards, with dwell timers and saturating move/mismatch scores.
//
// state      | meaning
// MAIN       | main menu, waiting for start
// DEBOUNCE   | short dwell after start click
// OPTIONS    | difficulty selection screen
// COMPUTE    | shuffle running, counters initialised
// UPDATE     | one-cycle redraw, routes to END / SETTLE / REVEAL
// SETTLE     | short dwell before accepting clicks
// WAIT_CLICK | waiting for a card click
// DISCOVER   | uncover the clicked card, store the pick
// REVEAL     | long dwell with the picked cards visible
// RESOLVE    | deactivate or cover every picked card
// END        | end screen
module match_group_fsm #(
    parameter int ADDR_W     = 5,
    parameter int COLOR_W    = 12,
    parameter int NUM_W      = 5,
    parameter int GROUP      = 2,
    parameter int WAIT_SHORT = 13_000_000,
    parameter int WAIT_LONG  = 26_000_000,
    parameter int SCORE_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_W-1:0]   num_of_cards,
    input  logic               start_butt_pressed,
    input  logic               difficulty_butts_pressed,
    input  logic               back_butt_pressed,
    input  logic               compute_done,
    input  logic               card_pressed,
    input  logic [ADDR_W-1:0]  card_clicked_address,
    input  logic [COLOR_W-1:0] card_clicked_color,
    output logic               start_butt_en,
    output logic               options_screen_en,
    output logic               start_game_en,
    output logic               update_cards_en,
    output logic               wait_for_click_en,
    output logic               write_card_en,
    output logic               end_screen_en,
    output logic [1:0]         write_card_state,
    output logic [ADDR_W-1:0]  write_card_address,
    output logic [SCORE_W-1:0] moves,
    output logic [SCORE_W-1:0] mismatches
);

    localparam int MAX_G    = 4;
    localparam int WAIT_MAX = (WAIT_LONG > WAIT_SHORT) ? WAIT_LONG : WAIT_SHORT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_MAIN       = 4'd0,
        S_DEBOUNCE   = 4'd1,
        S_OPTIONS    = 4'd2,
        S_COMPUTE    = 4'd3,
        S_UPDATE     = 4'd4,
        S_SETTLE     = 4'd5,
        S_WAIT_CLICK = 4'd6,
        S_DISCOVER   = 4'd7,
        S_REVEAL     = 4'd8,
        S_RESOLVE    = 4'd9,
        S_END        = 4'd10
    } state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [NUM_W-1:0]   cards_left;
    logic [2:0]         pick_cnt;
    logic [1:0]         res_idx;
    logic               mismatch_flag;
    logic [ADDR_W-1:0]  click_addr;
    logic [COLOR_W-1:0] click_color;
    logic [ADDR_W-1:0]  pick_addr  [MAX_G];
    logic [COLOR_W-1:0] pick_color [MAX_G];
    logic               dup_click;

    // A click on a card already picked this turn must not count as a new pick.
    always_comb begin
        dup_click = 1'b0;
        for (int i = 0; i < MAX_G; i++) begin
            if ((3'(i) < pick_cnt) && (pick_addr[i] == card_clicked_address)) begin
                dup_click = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_MAIN;
            wait_cnt           <= '0;
            cards_left         <= '0;
            pick_cnt           <= '0;
            res_idx            <= '0;
            mismatch_flag      <= 1'b0;
            click_addr         <= '0;
            click_color        <= '0;
            for (int i = 0; i < MAX_G; i++) begin
                pick_addr[i]  <= '0;
                pick_color[i] <= '0;
            end
            start_butt_en      <= 1'b0;
            options_screen_en  <= 1'b0;
            start_game_en      <= 1'b0;
            update_cards_en    <= 1'b0;
            wait_for_click_en  <= 1'b0;
            write_card_en      <= 1'b0;
            end_screen_en      <= 1'b0;
            write_card_state   <= 2'b00;
            write_card_address <= '0;
            moves              <= '0;
            mismatches         <= '0;
        end else begin
            start_butt_en     <= (state == S_MAIN);
            options_screen_en <= (state == S_OPTIONS);
            start_game_en     <= (state == S_COMPUTE);
            update_cards_en   <= (state == S_UPDATE);
            wait_for_click_en <= (state == S_WAIT_CLICK);
            end_screen_en     <= (state == S_END);
            write_card_en     <= 1'b0;

            case (state)
                S_MAIN: begin
                    if (start_butt_pressed) begin
                        state    <= S_DEBOUNCE;
                        wait_cnt <= '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (wait_cnt == WAIT_W'(WAIT_SHORT - 1)) state <= S_OPTIONS;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                S_OPTIONS: begin
                    if (difficulty_butts_pressed) state <= S_COMPUTE;
                    else if (back_butt_pressed) state <= S_MAIN;
                end
                S_COMPUTE: begin
                    cards_left    <= num_of_cards;
                    moves         <= '0;
                    mismatches    <= '0;
                    pick_cnt      <= '0;
                    mismatch_flag <= 1'b0;
                    if (compute_done) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    wait_cnt <= '0;
                    res_idx  <= '0;
                    // A finished turn must be shown before the end-of-deck test applies.
                    if (mismatch_flag || (pick_cnt == 3'(GROUP))) state <= S_REVEAL;
                    else if (cards_left < NUM_W'(GROUP)) state <= S_END;
                    else state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (wait_cnt == WAIT_W'(WAIT_SHORT - 1)) state <= S_WAIT_CLICK;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                S_WAIT_CLICK: begin
                    if (card_pressed && !dup_click) begin
                        click_addr  <= card_clicked_address;
                        click_color <= card_clicked_color;
                        state       <= S_DISCOVER;
                    end
                end
                S_DISCOVER: begin
                    write_card_en                <= 1'b1;
                    write_card_state             <= 2'b11;
                    write_card_address           <= click_addr;
                    pick_addr[pick_cnt[1:0]]     <= click_addr;
                    pick_color[pick_cnt[1:0]]    <= click_color;
                    pick_cnt                     <= pick_cnt + 3'd1;
                    if ((pick_cnt != 3'd0) && (click_color != pick_color[0])) mismatch_flag <= 1'b1;
                    state                        <= S_UPDATE;
                end
                S_REVEAL: begin
                    if (wait_cnt == WAIT_W'(WAIT_LONG - 1)) begin
                        state   <= S_RESOLVE;
                        res_idx <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESOLVE: begin
                    write_card_en      <= 1'b1;
                    write_card_address <= pick_addr[res_idx];
                    write_card_state   <= mismatch_flag ? 2'b01 : 2'b10;
                    if (3'(res_idx) == (pick_cnt - 3'd1)) begin
                        if (moves != '1) moves <= moves + 1'b1;
                        if (mismatch_flag) begin
                            if (mismatches != '1) mismatches <= mismatches + 1'b1;
                        end else if (cards_left >= NUM_W'(GROUP)) begin
                            cards_left <= cards_left - NUM_W'(GROUP);
                        end
                        pick_cnt      <= '0;
                        mismatch_flag <= 1'b0;
                        for (int i = 0; i < MAX_G; i++) begin
                            pick_addr[i]  <= '0;
                            pick_color[i] <= '0;
                        end
                        state <= S_UPDATE;
                    end else begin
                        res_idx <= res_idx + 1'b1;
                    end
                end
                S_END: begin
                    if (back_butt_pressed) state <= S_MAIN;
                end
                default: state <= S_MAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_match_group_fsm.sv
// Directed bench for match_group_fsm: menu flow, matching/mismatching turns, duplicate
// clicks, asynchronous reset mid-reveal, and a GROUP=3 instance sharing the stimulus.
module tb_match_group_fsm;

    localparam int ADDR_W  = 5;
    localparam int COLOR_W = 12;
    localparam int NUM_W   = 5;
    localparam int SCORE_W = 10;
    localparam logic [COLOR_W-1:0] COL_A = 12'h0A0;
    localparam logic [COLOR_W-1:0] COL_B = 12'h00B;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_W-1:0]   num_of_cards;
    logic               start_butt_pressed;
    logic               difficulty_butts_pressed;
    logic               back_butt_pressed;
    logic               compute_done;
    logic               card_pressed;
    logic [ADDR_W-1:0]  card_clicked_address;
    logic [COLOR_W-1:0] card_clicked_color;

    logic               start_butt_en, options_screen_en, start_game_en, update_cards_en;
    logic               wait_for_click_en, write_card_en, end_screen_en;
    logic [1:0]         write_card_state;
    logic [ADDR_W-1:0]  write_card_address;
    logic [SCORE_W-1:0] moves, mismatches;

    logic               start_butt_en_g3, options_screen_en_g3, start_game_en_g3, update_cards_en_g3;
    logic               wait_for_click_en_g3, write_card_en_g3, end_screen_en_g3;
    logic [1:0]         write_card_state_g3;
    logic [ADDR_W-1:0]  write_card_address_g3;
    logic [SCORE_W-1:0] moves_g3, mismatches_g3;

    always #5 clk = ~clk;

    match_group_fsm #(.GROUP(2), .WAIT_SHORT(4), .WAIT_LONG(8)) dut (
        .clk(clk), .rst(rst), .num_of_cards(num_of_cards),
        .start_butt_pressed(start_butt_pressed),
        .difficulty_butts_pressed(difficulty_butts_pressed),
        .back_butt_pressed(back_butt_pressed), .compute_done(compute_done),
        .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
        .card_clicked_color(card_clicked_color),
        .start_butt_en(start_butt_en), .options_screen_en(options_screen_en),
        .start_game_en(start_game_en), .update_cards_en(update_cards_en),
        .wait_for_click_en(wait_for_click_en), .write_card_en(write_card_en),
        .end_screen_en(end_screen_en), .write_card_state(write_card_state),
        .write_card_address(write_card_address), .moves(moves), .mismatches(mismatches)
    );

    match_group_fsm #(.GROUP(3), .WAIT_SHORT(4), .WAIT_LONG(8)) dut_g3 (
        .clk(clk), .rst(rst), .num_of_cards(num_of_cards),
        .start_butt_pressed(start_butt_pressed),
        .difficulty_butts_pressed(difficulty_butts_pressed),
        .back_butt_pressed(back_butt_pressed), .compute_done(compute_done),
        .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
        .card_clicked_color(card_clicked_color),
        .start_butt_en(start_butt_en_g3), .options_screen_en(options_screen_en_g3),
        .start_game_en(start_game_en_g3), .update_cards_en(update_cards_en_g3),
        .wait_for_click_en(wait_for_click_en_g3), .write_card_en(write_card_en_g3),
        .end_screen_en(end_screen_en_g3), .write_card_state(write_card_state_g3),
        .write_card_address(write_card_address_g3), .moves(moves_g3), .mismatches(mismatches_g3)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [6:0] wr_q[$];
    int         wr_cyc[$];
    logic [6:0] wr3_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (write_card_en) begin
            wr_q.push_back({write_card_address, write_card_state});
            wr_cyc.push_back(cyc);
        end
        if (write_card_en_g3) wr3_q.push_back({write_card_address_g3, write_card_state_g3});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {30'b0, start_butt_en, options_screen_en, start_game_en, update_cards_en,
                wait_for_click_en, write_card_en, end_screen_en, write_card_state,
                write_card_address, moves, mismatches};
    endfunction

    function automatic logic sel(input int s);
        case (s)
            0: return start_butt_en;
            1: return options_screen_en;
            2: return start_game_en;
            3: return wait_for_click_en;
            4: return end_screen_en;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int s, input string tag);
        int n = 0;
        while (sel(s) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sel(s)), 64'd1);
    endtask

    // 0 start, 1 difficulty, 2 back, 3 compute_done, 4 difficulty+back
    task automatic pulse(input int which);
        case (which)
            0: start_butt_pressed = 1'b1;
            1: difficulty_butts_pressed = 1'b1;
            2: back_butt_pressed = 1'b1;
            3: compute_done = 1'b1;
            default: begin
                difficulty_butts_pressed = 1'b1;
                back_butt_pressed = 1'b1;
            end
        endcase
        @(negedge clk);
        start_butt_pressed = 1'b0;
        difficulty_butts_pressed = 1'b0;
        back_butt_pressed = 1'b0;
        compute_done = 1'b0;
    endtask

    task automatic click(input logic [ADDR_W-1:0] a, input logic [COLOR_W-1:0] c);
        card_pressed = 1'b1;
        card_clicked_address = a;
        card_clicked_color = c;
        @(negedge clk);
        card_pressed = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_game();
        wait_sig(0, "main menu");
        pulse(0);
        wait_sig(1, "options screen");
        pulse(1);
        wait_sig(2, "compute");
        pulse(3);
        wait_sig(3, "first click ready");
    endtask

    task automatic check_wr(input bit g3, input int idx, input logic [ADDR_W-1:0] a, input logic [1:0] s);
        int sz;
        sz = g3 ? wr3_q.size() : wr_q.size();
        if (idx < sz) check($sformatf("write%s[%0d]", g3 ? "_g3" : "", idx),
                            64'(g3 ? wr3_q[idx] : wr_q[idx]), 64'({a, s}));
        else check($sformatf("write%s[%0d] present", g3 ? "_g3" : "", idx), 64'(sz), 64'(idx + 1));
    endtask

    initial begin
        rst = 1'b1;
        num_of_cards = 5'd4;
        start_butt_pressed = 1'b0;
        difficulty_butts_pressed = 1'b0;
        back_butt_pressed = 1'b0;
        compute_done = 1'b0;
        card_pressed = 1'b0;
        card_clicked_address = '0;
        card_clicked_color = '0;
        #1;
        check("reset outputs", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("start_en at release", 64'(start_butt_en), 64'd0);
        @(negedge clk);
        check("start_en after release", 64'(start_butt_en), 64'd1);

        // debounce dwell, back alone, then difficulty+back together
        pulse(0);
        repeat (4) @(negedge clk);
        check("debounce still dwelling", 64'(options_screen_en), 64'd0);
        @(negedge clk);
        check("options after debounce", 64'(options_screen_en), 64'd1);
        pulse(2);
        @(negedge clk);
        check("back alone to main", 64'(start_butt_en), 64'd1);
        check("options off after back", 64'(options_screen_en), 64'd0);
        pulse(0);
        wait_sig(1, "options again");
        pulse(4);
        @(negedge clk);
        check("difficulty wins", 64'(start_game_en), 64'd1);
        check("no main on both", 64'(start_butt_en), 64'd0);
        pulse(3);
        wait_sig(3, "game ready");

        // two matching pairs
        wr_q.delete();
        wr_cyc.delete();
        click(5'd0, COL_A);
        wait_sig(3, "T2 pick2 ready");
        click(5'd1, COL_A);
        wait_sig(3, "T2 turn1 done");
        click(5'd2, COL_B);
        wait_sig(3, "T2 pick4 ready");
        click(5'd3, COL_B);
        wait_sig(4, "T2 end screen");
        check("T2 write count", 64'(wr_q.size()), 64'd8);
        check_wr(1'b0, 0, 5'd0, 2'b11);
        check_wr(1'b0, 1, 5'd1, 2'b11);
        check_wr(1'b0, 2, 5'd0, 2'b10);
        check_wr(1'b0, 3, 5'd1, 2'b10);
        check_wr(1'b0, 4, 5'd2, 2'b11);
        check_wr(1'b0, 5, 5'd3, 2'b11);
        check_wr(1'b0, 6, 5'd2, 2'b10);
        check_wr(1'b0, 7, 5'd3, 2'b10);
        if (wr_cyc.size() >= 4) begin
            check("T2 reveal gap", 64'(wr_cyc[2] - wr_cyc[1]), 64'd10);
            check("T2 resolve back-to-back", 64'(wr_cyc[3] - wr_cyc[2]), 64'd1);
        end
        check("T2 moves", 64'(moves), 64'd2);
        check("T2 mismatches", 64'(mismatches), 64'd0);
        pulse(2);

        // mismatch, then duplicate click, then finish the deck
        start_game();
        wr_q.delete();
        wr_cyc.delete();
        click(5'd0, COL_A);
        wait_sig(3, "T3 pick2 ready");
        click(5'd2, COL_B);
        wait_sig(3, "T3 turn done");
        check("T3 write count", 64'(wr_q.size()), 64'd4);
        check_wr(1'b0, 2, 5'd0, 2'b01);
        check_wr(1'b0, 3, 5'd2, 2'b01);
        if (wr_cyc.size() >= 4) check("T3 cover back-to-back", 64'(wr_cyc[3] - wr_cyc[2]), 64'd1);
        check("T3 mismatches", 64'(mismatches), 64'd1);
        check("T3 moves", 64'(moves), 64'd1);

        wr_q.delete();
        click(5'd3, COL_B);
        wait_sig(3, "T4 pick2 ready");
        click(5'd3, COL_B);
        check("T4 dup no write", 64'(wr_q.size()), 64'd1);
        check("T4 dup stays waiting", 64'(wait_for_click_en), 64'd1);
        click(5'd1, COL_A);
        wait_sig(3, "T4 turn done");
        check_wr(1'b0, 1, 5'd1, 2'b11);
        check_wr(1'b0, 2, 5'd3, 2'b01);
        check_wr(1'b0, 3, 5'd1, 2'b01);
        check("T4 moves", 64'(moves), 64'd2);
        check("T4 mismatches", 64'(mismatches), 64'd2);
        click(5'd0, COL_A);
        wait_sig(3, "T4 pick ready");
        click(5'd1, COL_A);
        wait_sig(3, "T4 deck not over");
        click(5'd2, COL_B);
        wait_sig(3, "T4 last pick ready");
        click(5'd3, COL_B);
        wait_sig(4, "T4 end screen");
        check("T4 final moves", 64'(moves), 64'd4);
        check("T4 final mismatches", 64'(mismatches), 64'd2);
        pulse(2);

        // asynchronous reset in the middle of REVEAL
        start_game();
        click(5'd0, COL_A);
        wait_sig(3, "T1 pick2 ready");
        click(5'd2, COL_B);
        wait_sig(3, "T1 turn done");
        click(5'd0, COL_A);
        wait_sig(3, "T1 pick4 ready");
        click(5'd1, COL_A);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("T1 outputs zero on reset", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("T1 start_en at release", 64'(start_butt_en), 64'd0);
        @(negedge clk);
        check("T1 start_en after release", 64'(start_butt_en), 64'd1);

        // GROUP=3 instance: early mismatch, then a full group of three
        wr3_q.delete();
        start_game();
        click(5'd0, COL_A);
        wait_sig(3, "T5 pick2 ready");
        click(5'd1, COL_B);
        wait_sig(3, "T5 turn done");
        check("T5 write count", 64'(wr3_q.size()), 64'd4);
        check_wr(1'b1, 0, 5'd0, 2'b11);
        check_wr(1'b1, 1, 5'd1, 2'b11);
        check_wr(1'b1, 2, 5'd0, 2'b01);
        check_wr(1'b1, 3, 5'd1, 2'b01);
        check("T5 moves", 64'(moves_g3), 64'd1);
        check("T5 mismatches", 64'(mismatches_g3), 64'd1);
        wr3_q.delete();
        click(5'd0, COL_A);
        repeat (8) @(negedge clk);
        click(5'd1, COL_A);
        repeat (8) @(negedge clk);
        check("T5 two of three keeps clicking", 64'(wait_for_click_en_g3), 64'd1);
        check("T5 no resolve after two", 64'(wr3_q.size()), 64'd2);
        click(5'd2, COL_A);
        repeat (20) @(negedge clk);
        check("T5 group write count", 64'(wr3_q.size()), 64'd6);
        check_wr(1'b1, 3, 5'd0, 2'b10);
        check_wr(1'b1, 4, 5'd1, 2'b10);
        check_wr(1'b1, 5, 5'd2, 2'b10);
        check("T5 group moves", 64'(moves_g3), 64'd2);
        check("T5 group mismatches", 64'(mismatches_g3), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1);
    end

endmodule
